// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel position, data-enable, sync pulses,
// line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          hs,
    output logic          vs,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW) begin : g_size_err
            $error("vga_timing_gen: raster totals exceed 2**CW");
        end
    endgenerate

    localparam logic [CW-1:0] H_MAX = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX = CW'(V_TOTAL - 1);

    // One extra bit so bounds equal to 2**CW still compare correctly
    localparam logic [CW:0] H_DE_END = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] H_SY_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SY_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_DE_END = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] V_SY_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SY_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic [CW:0]   xw;
    logic [CW:0]   yw;
    logic          x_wrap;
    logic          de_nxt;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          ls_nxt;
    logic          fs_nxt;
    logic [FW-1:0] fc_nxt;

    always_comb begin
        x_nxt  = x;
        y_nxt  = y;
        x_wrap = (x == H_MAX);
        ls_nxt = 1'b0;
        fs_nxt = 1'b0;
        if (pix_en) begin
            if (x_wrap) begin
                x_nxt  = '0;
                y_nxt  = (y == V_MAX) ? '0 : y + CW'(1);
                ls_nxt = 1'b1;
                fs_nxt = (y == V_MAX);
            end else begin
                x_nxt = x + CW'(1);
            end
        end
        xw     = {1'b0, x_nxt};
        yw     = {1'b0, y_nxt};
        de_nxt = (xw < H_DE_END) && (yw < V_DE_END);
        hs_nxt = (xw >= H_SY_BEG && xw < H_SY_END) ? HS_POL : ~HS_POL;
        vs_nxt = (yw >= V_SY_BEG && yw < V_SY_END) ? VS_POL : ~VS_POL;
        fc_nxt = frame_cnt + FW'(fs_nxt);
    end

    // Flags are computed from the next position, so they line up with x,y
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b1;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            x           <= x_nxt;
            y           <= y_nxt;
            de          <= de_nxt;
            hs          <= hs_nxt;
            vs          <= vs_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
            frame_cnt   <= fc_nxt;
        end
    end

endmodule
